// File: rtl/pc_fetch_control.sv
// Program-counter register and next-PC sequencer feeding PCAdder and instruction memory.
// Arbitrates halt / jump / branch / stall / memory-wait and counts completed fetches.
//
// state | meaning
// BOOT  | one settling cycle after reset release, no fetch issued, PC held
// RUN   | live fetch at PCResult, next-PC arbitration active
// HALT  | halt decoded, PC frozen, exit only via reset
// TRAP  | misaligned redirect target, PC frozen, exit only via reset
module pc_fetch_control #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_INC       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        IMemReady,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Halt,
    output logic [31:0] PCResult,
    output logic        FetchValid,
    output logic        Halted,
    output logic        MisalignTrap,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_TRAP = 2'd3
    } state_e;

    // Word fetch: any target bit below the increment granule is a misalignment.
    localparam logic [31:0] ALIGN_MASK = 32'(PC_INC - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        halted_q, halted_d;
    logic        trap_q, trap_d;

    logic        fetch_done;
    logic        jump_misaligned;
    logic        branch_misaligned;

    always_comb begin
        fetch_done        = (state_q == ST_RUN) && IMemReady && !Stall;
        jump_misaligned   = |(JumpTarget & ALIGN_MASK);
        branch_misaligned = |(BranchTarget & ALIGN_MASK);

        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALT;
                end else begin
                    // A completing fetch counts even when the same edge redirects.
                    if (fetch_done) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                    if (Jump) begin
                        if (jump_misaligned) begin
                            state_d = ST_TRAP;
                        end else begin
                            pc_d = JumpTarget;
                        end
                    end else if (BranchTaken) begin
                        if (branch_misaligned) begin
                            state_d = ST_TRAP;
                        end else begin
                            pc_d = BranchTarget;
                        end
                    end else if (fetch_done) begin
                        pc_d = PCAddResult;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        fetch_valid_d = (state_d == ST_RUN);
        halted_d      = (state_d == ST_HALT);
        trap_d        = (state_d == ST_TRAP);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_count_q <= 32'd0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            trap_q        <= trap_d;
        end
    end

    assign PCResult     = pc_q;
    assign FetchValid   = fetch_valid_q;
    assign Halted       = halted_q;
    assign MisalignTrap = trap_q;
    assign FetchCount   = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Bench for pc_fetch_control: behavioural next-PC model checked every negedge,
// plus directed vectors with literal expectations.
module tb_pc_fetch_control;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] INC = 32'd4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        IMemReady = 1'b0;
    logic        BranchTaken = 1'b0;
    logic        Jump = 1'b0;
    logic        Halt = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic [31:0] JumpTarget = 32'd0;
    logic [31:0] PCAddResult;
    logic [31:0] PCResult;
    logic [31:0] FetchCount;
    logic        FetchValid;
    logic        Halted;
    logic        MisalignTrap;

    int checks = 0;
    int errors = 0;

    pc_fetch_control #(.RESET_VECTOR(RV), .PC_INC(4)) dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .Stall(Stall),
        .IMemReady(IMemReady), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Halt(Halt), .PCResult(PCResult),
        .FetchValid(FetchValid), .Halted(Halted), .MisalignTrap(MisalignTrap),
        .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    // PCAdder in the loop
    assign PCAddResult = PCResult + INC;

    // Behavioural model: mode flags, PC and fetch count
    logic [31:0] m_pc = RV;
    logic [31:0] m_cnt = 32'd0;
    bit m_boot = 1'b1, m_run = 1'b0, m_halt = 1'b0, m_trap = 1'b0;

    always @(posedge Clk or negedge Reset) begin
        bit done;
        if (!Reset) begin
            m_boot = 1; m_run = 0; m_halt = 0; m_trap = 0;
            m_pc = RV; m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 0; m_run = 1;
        end else if (m_run) begin
            done = IMemReady && !Stall;
            if (Halt) begin
                m_run = 0; m_halt = 1;
            end else begin
                if (done) m_cnt = m_cnt + 1;
                if (Jump) begin
                    if ((JumpTarget % 4) != 0) begin m_run = 0; m_trap = 1; end
                    else m_pc = JumpTarget;
                end else if (BranchTaken) begin
                    if ((BranchTarget % 4) != 0) begin m_run = 0; m_trap = 1; end
                    else m_pc = BranchTarget;
                end else if (done) begin
                    m_pc = m_pc + INC;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        chk("model_pc", PCResult, m_pc);
        chk("model_count", FetchCount, m_cnt);
        chk("model_valid", {31'b0, FetchValid}, {31'b0, m_run});
        chk("model_halted", {31'b0, Halted}, {31'b0, m_halt});
        chk("model_trap", {31'b0, MisalignTrap}, {31'b0, m_trap});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic ctl(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
        Jump = j; JumpTarget = jt; BranchTaken = b; BranchTarget = bt;
    endtask

    task automatic lit(input string name, input logic [31:0] pc, input logic [31:0] cnt,
                       input logic fv, input logic hl, input logic tr);
        chk({name, "_pc"}, PCResult, pc);
        chk({name, "_cnt"}, FetchCount, cnt);
        chk({name, "_fv"}, {31'b0, FetchValid}, {31'b0, fv});
        chk({name, "_halt"}, {31'b0, Halted}, {31'b0, hl});
        chk({name, "_trap"}, {31'b0, MisalignTrap}, {31'b0, tr});
    endtask

    initial begin
        #1 Reset = 1'b0;
        IMemReady = 1'b1;
        cyc(2);
        lit("reset", 32'h0, 0, 0, 0, 0);
        Reset = 1'b1;
        #1 lit("boot", 32'h0, 0, 0, 0, 0);
        cyc(1); lit("run0", 32'h0, 0, 1, 0, 0);
        cyc(1); lit("seq4", 32'h4, 1, 1, 0, 0);
        cyc(1); lit("seq8", 32'h8, 2, 1, 0, 0);
        cyc(1); lit("seq12", 32'hC, 3, 1, 0, 0);
        cyc(1); lit("seq16", 32'h10, 4, 1, 0, 0);

        Stall = 1'b1;
        cyc(3); lit("stall", 32'h10, 4, 1, 0, 0);
        Stall = 1'b0;
        cyc(1); lit("unstall", 32'h14, 5, 1, 0, 0);

        IMemReady = 1'b0; ctl(1, 32'h100, 0, 0);
        cyc(1); lit("jump_wait", 32'h100, 5, 1, 0, 0);
        IMemReady = 1'b1; ctl(1, 32'h200, 1, 32'h300);
        cyc(1); lit("jump_over_br", 32'h200, 6, 1, 0, 0);
        ctl(1, 32'h40, 0, 0);
        cyc(1); lit("jump40", 32'h40, 7, 1, 0, 0);
        Halt = 1'b1; ctl(1, 32'h80, 0, 0);
        cyc(1); lit("halt", 32'h40, 7, 0, 1, 0);
        Halt = 1'b0; ctl(1, 32'h500, 1, 32'h600);
        cyc(2); lit("halt_hold", 32'h40, 7, 0, 1, 0);
        ctl(0, 0, 0, 0);

        Reset = 1'b0;
        cyc(1); lit("reset2", 32'h0, 0, 0, 0, 0);
        Reset = 1'b1;
        cyc(1); lit("run2", 32'h0, 0, 1, 0, 0);
        ctl(1, 32'h100, 0, 0);
        cyc(1); lit("jump100", 32'h100, 1, 1, 0, 0);
        ctl(0, 0, 1, 32'h102);
        cyc(1); lit("br_trap", 32'h100, 2, 0, 0, 1);
        ctl(0, 0, 0, 0);
        cyc(2); lit("trap_hold", 32'h100, 2, 0, 0, 1);
        Reset = 1'b0;
        #1 lit("trap_reset", RV, 0, 0, 0, 0);
        cyc(1);
        Reset = 1'b1;
        cyc(1); lit("run3", 32'h0, 0, 1, 0, 0);

        ctl(1, 32'h20, 1, 32'h3);
        cyc(1); lit("jump_mis_br", 32'h20, 1, 1, 0, 0);
        ctl(1, 32'hFFFF_FFFC, 0, 0);
        cyc(1); lit("jump_top", 32'hFFFF_FFFC, 2, 1, 0, 0);
        ctl(0, 0, 0, 0);
        cyc(1); lit("pc_wrap", 32'h0, 3, 1, 0, 0);
        ctl(1, 32'h6, 0, 0);
        cyc(1); lit("jump_trap", 32'h0, 4, 0, 0, 1);
        ctl(0, 0, 0, 0);

        Reset = 1'b0;
        cyc(1);
        Reset = 1'b1;
        cyc(3); lit("run4", 32'h8, 2, 1, 0, 0);
        #2 Reset = 1'b0;
        #1 lit("async_reset", RV, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        cyc(2); lit("run5", 32'h4, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_control.md
Name: pc_fetch_control

Overview:
- Program-counter register and next-PC sequencer that sits directly upstream of PCAdder.
- Drives PCResult into PCAdder and instruction memory.
- Takes PCAddResult back as the sequential next address.
- Arbitrates jump, branch, stall, halt and memory-wait conditions with a small state machine, and counts completed fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- PC_INC, 4, increment PCAdder applies; used only for the bench checker and the alignment mask assumption (word fetch).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PCAddResult  in  32  PCResult + PC_INC from PCAdder.
- Stall  in  1  hazard-unit stall; holds the PC for sequential advance.
- IMemReady  in  1  instruction memory accepts the current fetch this cycle.
- BranchTaken  in  1  resolved taken branch.
- BranchTarget  in  32  branch destination.
- Jump  in  1  jump / jr redirect.
- JumpTarget  in  32  jump destination.
- Halt  in  1  halt instruction decoded.
- PCResult  out  32  current fetch address.
- FetchValid  out  1  PCResult is a live fetch request.
- Halted  out  1  block is in HALT.
- MisalignTrap  out  1  block is in TRAP.
- FetchCount  out  32  number of completed fetches.

Behaviour:
- Reset (Reset=0, asynchronous) forces the following; these hold while Reset=0:
  - PCResult=RESET_VECTOR
  - FetchValid=0, Halted=0, MisalignTrap=0
  - FetchCount=0
  - state=BOOT
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- States:
  - BOOT: exactly one cycle after Reset deasserts, FetchValid=0, PC holds; then go to RUN.
  - RUN: FetchValid=1.
  - HALT: FetchValid=0, Halted=1, PC frozen; leave only via Reset.
  - TRAP: FetchValid=0, MisalignTrap=1, PC frozen; leave only via Reset.
- Fetch completion: a cycle in RUN with IMemReady=1 and Stall=0.
- Next-PC priority in RUN, evaluated each rising edge:
  1. Halt=1 -> HALT; PC unchanged; FetchCount unchanged.
  2. Jump=1 with JumpTarget[1:0]!=0 -> TRAP; PC unchanged.
  3. Jump=1 -> PC=JumpTarget.
  4. BranchTaken=1 with BranchTarget[1:0]!=0 -> TRAP; PC unchanged.
  5. BranchTaken=1 -> PC=BranchTarget.
  6. Fetch completion -> PC=PCAddResult.
  7. Otherwise -> PC holds.
- Redirects (rows 2-5) take effect on the next edge regardless of Stall and IMemReady; the in-flight fetch is abandoned.
- Jump wins over BranchTaken when both are asserted. A misaligned BranchTarget is ignored when Jump=1.
- FetchCount increments by 1 on every fetch completion, including completion cycles that also redirect.
- FetchCount wraps from 32'hFFFF_FFFF to 0.
- Sequential wrap: PCResult=32'hFFFF_FFFC with PCAddResult=0 -> PC=0. This is not a trap.
- PCAddResult is used verbatim; the block does not re-add.
- Inputs are ignored in BOOT, HALT and TRAP.
- Reset asserted mid-operation in any state returns the block to BOOT at once.

Test Plan:
- Reset release, IMemReady=1, Stall=0, PCAdder in loop:
  - one BOOT cycle with FetchValid=0, then PCResult=0,4,8,12 on successive edges;
  - FetchCount=1,2,3 after the first three advances.
- Stall=1 for 3 cycles at PC=0x10, then Stall=0:
  - PC holds at 0x10 for 3 edges, then 0x14;
  - FetchCount does not advance while stalled.
- IMemReady=0 with Jump=1, JumpTarget=0x100 in the same cycle:
  - next PC=0x100; FetchCount unchanged.
- Jump=1, JumpTarget=0x200 together with BranchTaken=1, BranchTarget=0x300:
  - PC=0x200.
- BranchTaken=1, BranchTarget=0x102:
  - TRAP; MisalignTrap=1, FetchValid=0, PC frozen at its prior value;
  - Reset=0 pulse restores PC=RESET_VECTOR.
- Halt=1 at PC=0x40 with Jump=1:
  - HALT; Halted=1, PC stays 0x40;
  - later Jump/BranchTaken ignored;
  - PC=32'hFFFF_FFFC with no redirect advances to 0.
